data_mem_ctrl: RTL and testbench

Parametrised single-port data memory for the CPU datapath: configurable word width, depth and byte-lane write masking, with a req/ready handshake, one-cycle registered read and an error pulse for bad accesses. After reset or a software clear, it zeroes every word sequentially, one word per clock, instead of through a parallel reset of the whole array. A configurable number of low-address words is mirrored into reset-able debug tap registers for the register/LED display.

---
 rtl/data_mem_ctrl_if.sv | 33 +++
 rtl/data_mem_ctrl.sv | 146 ++++++++++++++
 tb/tb_data_mem_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_if.sv
// Bus bundle for data_mem_ctrl: request/response handshake, clear request
// and the flattened debug tap mirror.
interface data_mem_ctrl_if #(
    parameter int DATA_W = 24,
    parameter int LANE_W = 8,
    parameter int ADDR_W = 8,
    parameter int TAPS   = 4
) ();
    localparam int NLANE = DATA_W / LANE_W;

    logic                   clr;
    logic                   req;
    logic                   we;
    logic [NLANE-1:0]       wmask;
    logic [ADDR_W-1:0]      addr;
    logic [DATA_W-1:0]      din;
    logic                   ready;
    logic                   busy;
    logic                   rvalid;
    logic [DATA_W-1:0]      dout;
    logic                   err;
    logic [TAPS*DATA_W-1:0] taps;

    modport master (
        output clr, req, we, wmask, addr, din,
        input  ready, busy, rvalid, dout, err, taps
    );

    modport slave (
        input  clr, req, we, wmask, addr, din,
        output ready, busy, rvalid, dout, err, taps
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Single-port data memory with lane-masked writes, one-cycle registered
// read, error pulse on bad accesses, sequential zero-clear after reset or
// clr, and reset-able mirror registers for the lowest TAPS words.
module data_mem_ctrl #(
    parameter int DATA_W = 24,
    parameter int LANE_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int TAPS   = 4
) (
    input  logic           clk,
    input  logic           rst,
    data_mem_ctrl_if.slave bus
);
    localparam int NLANE = DATA_W / LANE_W;
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_t;

    state_t             state, state_d;
    logic [ADDR_W-1:0]  ptr, ptr_d;

    logic               ready, busy;
    logic               addr_bad;
    logic               acc;
    logic [NLANE-1:0]   mem_wlane;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [DATA_W-1:0]  mem_wdata;

    logic [DATA_W-1:0]  mem   [DEPTH];
    logic [DATA_W-1:0]  tap_q [TAPS];

    // State and clear-pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_d;
            ptr   <= ptr_d;
        end
    end

    // Next state: walk ptr through the array while clearing; clr restarts it
    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        case (state)
            S_CLEAR: begin
                if (bus.clr) begin
                    ptr_d = '0;
                end else if (ptr == LAST) begin
                    state_d = S_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr + ADDR_W'(1);
                end
            end
            S_IDLE: begin
                if (bus.clr) begin
                    state_d = S_CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = S_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    // Outputs and access decode; the clear pass and host writes share one write port
    always_comb begin
        ready     = (state == S_IDLE);
        busy      = (state == S_CLEAR);
        addr_bad  = ({1'b0, bus.addr} >= DEPTH_X);
        acc       = ready && bus.req && !bus.clr;
        mem_wlane = '0;
        mem_waddr = ptr;
        mem_wdata = '0;
        if (busy) begin
            mem_wlane = '1;
        end else if (acc && bus.we && !addr_bad) begin
            mem_wlane = bus.wmask;
            mem_waddr = bus.addr;
            mem_wdata = bus.din;
        end
        bus.ready = ready;
        bus.busy  = busy;
    end

    // Memory array write, lane by lane; no reset on the array itself
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < NLANE; k++) begin
            if (mem_wlane[k]) begin
                mem[mem_waddr][k*LANE_W +: LANE_W] <= mem_wdata[k*LANE_W +: LANE_W];
            end
        end
    end

    // Tap mirror follows the same write port as the array, but has a reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < TAPS; i++) begin
                tap_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < TAPS; i++) begin
                if (mem_waddr == ADDR_W'(i)) begin
                    for (int unsigned k = 0; k < NLANE; k++) begin
                        if (mem_wlane[k]) begin
                            tap_q[i][k*LANE_W +: LANE_W] <= mem_wdata[k*LANE_W +: LANE_W];
                        end
                    end
                end
            end
        end
    end

    // Read response and error pulse, one cycle after the request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rvalid <= 1'b0;
            bus.err    <= 1'b0;
            bus.dout   <= '0;
        end else begin
            bus.rvalid <= acc && !bus.we;
            bus.err    <= (ready && bus.req && bus.clr) || (acc && addr_bad);
            if (acc && !bus.we) begin
                bus.dout <= addr_bad ? '0 : mem[bus.addr];
            end
        end
    end

    // Flatten the tap mirror onto the output bus
    always_comb begin
        bus.taps = '0;
        for (int unsigned i = 0; i < TAPS; i++) begin
            bus.taps[i*DATA_W +: DATA_W] = tap_q[i];
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: one default instance (DEPTH=256) and
// one with DEPTH=200 for out-of-range address checks.
module tb_data_mem_ctrl;
    typedef struct packed {
        logic        rv;
        logic        er;
        logic [23:0] d;
    } exp_t;

    logic clk;
    logic rst;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [23:0] model_a [256];
    logic [23:0] model_b [256];

    data_mem_ctrl_if #(.DATA_W(24), .LANE_W(8), .ADDR_W(8), .TAPS(4)) ifa ();
    data_mem_ctrl_if #(.DATA_W(24), .LANE_W(8), .ADDR_W(8), .TAPS(4)) ifb ();

    data_mem_ctrl #(.DATA_W(24), .LANE_W(8), .ADDR_W(8), .DEPTH(256), .TAPS(4)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    data_mem_ctrl #(.DATA_W(24), .LANE_W(8), .ADDR_W(8), .DEPTH(200), .TAPS(4)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] merge(input logic [23:0] old, input logic [2:0] m,
                                          input logic [23:0] d);
        logic [23:0] r;
        r = old;
        for (int k = 0; k < 3; k++) begin
            if (m[k]) r[k*8 +: 8] = d[k*8 +: 8];
        end
        return r;
    endfunction

    // One access per call; returns one cycle later so calls can run back-to-back
    task automatic access(input int which, input logic w, input logic [2:0] m,
                          input logic [7:0] ad, input logic [23:0] d);
        exp_t        e;
        int unsigned dep;
        dep = (which == 0) ? 256 : 200;
        e   = '0;
        if (int'(ad) >= dep) begin
            e.rv = !w;
            e.er = 1'b1;
            e.d  = '0;
        end else if (!w) begin
            e.rv = 1'b1;
            e.d  = (which == 0) ? model_a[ad] : model_b[ad];
        end else if (which == 0) begin
            model_a[ad] = merge(model_a[ad], m, d);
        end else begin
            model_b[ad] = merge(model_b[ad], m, d);
        end
        if (which == 0) begin
            check("a_ready_before_access", ifa.ready, 1'b1);
            ifa.req = 1'b1; ifa.we = w; ifa.wmask = m; ifa.addr = ad; ifa.din = d;
        end else begin
            check("b_ready_before_access", ifb.ready, 1'b1);
            ifb.req = 1'b1; ifb.we = w; ifb.wmask = m; ifb.addr = ad; ifb.din = d;
        end
        @(posedge clk);
        #1;
        if (which == 0) begin
            ifa.req = 1'b0;
            qa.push_back(e);
        end else begin
            ifb.req = 1'b0;
            qb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Count edges until each instance reports ready, bounded
    task automatic wait_ready(output int na, output int nb);
        na = 0;
        nb = 0;
        for (int c = 0; c < 1000 && !(ifa.ready && ifb.ready); c++) begin
            if (!ifa.ready) na++;
            if (!ifb.ready) nb++;
            @(posedge clk);
            #1;
        end
    endtask

    // Response monitors: pop one expectation per accepted request, else expect silence
    always @(negedge clk) begin
        exp_t e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            check("a_rvalid", ifa.rvalid, e.rv);
            check("a_err", ifa.err, e.er);
            if (e.rv) check("a_dout", ifa.dout, e.d);
        end else begin
            check("a_idle_rvalid", ifa.rvalid, 1'b0);
            check("a_idle_err", ifa.err, 1'b0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (qb.size() > 0) begin
            e = qb.pop_front();
            check("b_rvalid", ifb.rvalid, e.rv);
            check("b_err", ifb.err, e.er);
            if (e.rv) check("b_dout", ifb.dout, e.d);
        end else begin
            check("b_idle_rvalid", ifb.rvalid, 1'b0);
            check("b_idle_err", ifb.err, 1'b0);
        end
    end

    initial begin
        int na, nb;
        rst = 1'b1;
        ifa.clr = 1'b0; ifa.req = 1'b0; ifa.we = 1'b0; ifa.wmask = '0; ifa.addr = '0; ifa.din = '0;
        ifb.clr = 1'b0; ifb.req = 1'b0; ifb.we = 1'b0; ifb.wmask = '0; ifb.addr = '0; ifb.din = '0;
        for (int i = 0; i < 256; i++) begin
            model_a[i] = '0;
            model_b[i] = '0;
        end

        idle(3);
        check("rst_ready", ifa.ready, 1'b0);
        check("rst_busy", ifa.busy, 1'b1);
        check("rst_dout", ifa.dout, 24'h0);
        check("rst_taps", ifa.taps, 96'h0);
        rst = 1'b0;

        wait_ready(na, nb);
        check("a_clear_len", na, 256);
        check("b_clear_len", nb, 200);
        check("a_busy_after_clear", ifa.busy, 1'b0);

        // Read after clear, then full and masked writes with back-to-back reads
        access(0, 1'b0, 3'b000, 8'd200, 24'h0);
        access(0, 1'b1, 3'b111, 8'd5, 24'hABCDEF);
        access(0, 1'b0, 3'b000, 8'd5, 24'h0);
        idle(3);
        check("a_dout_holds", ifa.dout, 24'hABCDEF);
        access(0, 1'b1, 3'b111, 8'd2, 24'hABCDEF);
        access(0, 1'b1, 3'b010, 8'd2, 24'h123456);
        check("a_tap2_masked", ifa.taps[2*24 +: 24], 24'hAB34EF);
        access(0, 1'b0, 3'b000, 8'd2, 24'h0);
        access(0, 1'b1, 3'b000, 8'd2, 24'hFFFFFF);
        access(0, 1'b0, 3'b000, 8'd2, 24'h0);
        access(0, 1'b1, 3'b101, 8'd255, 24'h5A5A5A);
        access(0, 1'b0, 3'b000, 8'd255, 24'h0);

        // Out-of-range accesses on the DEPTH=200 instance
        access(1, 1'b1, 3'b111, 8'd199, 24'h777777);
        access(1, 1'b1, 3'b111, 8'd210, 24'hDEAD01);
        access(1, 1'b1, 3'b111, 8'd200, 24'hDEAD02);
        access(1, 1'b0, 3'b000, 8'd210, 24'h0);
        access(1, 1'b0, 3'b000, 8'd199, 24'h0);
        access(1, 1'b0, 3'b000, 8'd10, 24'h0);
        check("b_taps_untouched", ifb.taps, 96'h0);

        // Fill taps, then clr coincident with a write
        for (int i = 0; i < 4; i++) begin
            access(0, 1'b1, 3'b111, 8'(i), 24'h100000 + 24'(i * 24'h010101));
        end
        check("a_taps_filled", ifa.taps,
              {24'h130303, 24'h120202, 24'h110101, 24'h100000});
        ifa.clr = 1'b1; ifa.req = 1'b1; ifa.we = 1'b1; ifa.addr = 8'd1;
        ifa.din = 24'h111111; ifa.wmask = 3'b111;
        @(posedge clk);
        #1;
        qa.push_back('{rv: 1'b0, er: 1'b1, d: 24'h0});
        ifa.clr = 1'b0; ifa.req = 1'b0;
        for (int i = 0; i < 256; i++) model_a[i] = '0;
        wait_ready(na, nb);
        check("a_clr_len", na, 256);
        check("a_taps_cleared", ifa.taps, 96'h0);
        access(0, 1'b0, 3'b000, 8'd1, 24'h0);
        access(0, 1'b0, 3'b000, 8'd5, 24'h0);

        // Reset in the middle of a clear pass
        access(0, 1'b1, 3'b111, 8'd0, 24'hC0FFEE);
        access(0, 1'b0, 3'b000, 8'd0, 24'h0);
        ifa.clr = 1'b1;
        @(posedge clk);
        #1;
        ifa.clr = 1'b0;
        idle(100);
        check("a_mid_clear_busy", ifa.busy, 1'b1);
        check("a_mid_clear_dout", ifa.dout, 24'hC0FFEE);
        rst = 1'b1;
        #2;
        check("a_rst_dout", ifa.dout, 24'h0);
        check("a_rst_busy", ifa.busy, 1'b1);
        check("b_rst_ready", ifb.ready, 1'b0);
        idle(2);
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            model_a[i] = '0;
            model_b[i] = '0;
        end
        wait_ready(na, nb);
        check("a_clear_len_after_rst", na, 256);
        check("b_clear_len_after_rst", nb, 200);
        access(0, 1'b0, 3'b000, 8'd0, 24'h0);
        access(1, 1'b0, 3'b000, 8'd199, 24'h0);
        idle(3);
        check("scoreboard_drained", qa.size() + qb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
